// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out bundle for conv_window_buffer.
// The slave side is the window generator; the master side is the pixel source and the window sink.
interface conv_window_buffer_if #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNEL_IN = 8,
    parameter int KERNEL     = 3
);
    logic [DATA_WIDHT*CHANNEL_IN-1:0]               Data_In;
    logic                                           Valid_In;
    logic [DATA_WIDHT*CHANNEL_IN*KERNEL*KERNEL-1:0] Data_Out;
    logic                                           Valid_Out;
    logic                                           Frame_Done;

    modport master (output Data_In, Valid_In, input Data_Out, Valid_Out, Frame_Done);
    modport slave  (input Data_In, Valid_In, output Data_Out, Valid_Out, Frame_Done);
endinterface

// File: rtl/conv_window_buffer.sv
// Sliding KERNELxKERNEL window generator over a raster pixel stream, with stride and frame-done pulse.
// The window is registered and visible 1 cycle after the completing beat; there is no backpressure.
module conv_window_buffer #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNEL_IN = 8,
    parameter int IMG_WIDHT  = 44,
    parameter int IMG_HEIGHT = 44,
    parameter int KERNEL     = 3,
    parameter int STRIDE     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_buffer_if.slave  bus
);
    localparam int PW  = DATA_WIDHT * CHANNEL_IN;
    localparam int CW  = $clog2(IMG_WIDHT);
    localparam int RW  = $clog2(IMG_HEIGHT);
    localparam int PHW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [PHW-1:0] cph;
    logic [PHW-1:0] rph;

    logic [PW-1:0] lb      [KERNEL-1][IMG_WIDHT];
    logic [PW-1:0] win     [KERNEL][KERNEL];
    logic [PW-1:0] win_nxt [KERNEL][KERNEL];
    logic [PW-1:0] tap     [KERNEL];
    logic [PW*KERNEL*KERNEL-1:0] out_nxt;

    logic col_last;
    logic row_last;
    logic emit;

    assign col_last = (col == CW'(IMG_WIDHT - 1));
    assign row_last = (row == RW'(IMG_HEIGHT - 1));
    assign emit     = bus.Valid_In && (row >= RW'(KERNEL - 1)) && (col >= CW'(KERNEL - 1)) &&
                      (rph == '0) && (cph == '0);

    // tap[0] is the incoming (bottom) row, tap[KERNEL-1] the oldest row.
    always_comb begin
        tap[0] = bus.Data_In;
        for (int j = 1; j < KERNEL; j++) begin
            tap[j] = lb[j-1][col];
        end
        for (int r = 0; r < KERNEL; r++) begin
            for (int k = 0; k < KERNEL - 1; k++) begin
                win_nxt[r][k] = win[r][k+1];
            end
            win_nxt[r][KERNEL-1] = tap[KERNEL-1-r];
        end
        out_nxt = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int k = 0; k < KERNEL; k++) begin
                out_nxt[(r*KERNEL+k)*PW +: PW] = win_nxt[r][k];
            end
        end
    end

    // Phase counters are cleared on the beat that moves onto index KERNEL-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            col            <= '0;
            row            <= '0;
            cph            <= '0;
            rph            <= '0;
            bus.Valid_Out  <= 1'b0;
            bus.Frame_Done <= 1'b0;
            bus.Data_Out   <= '0;
        end else begin
            bus.Valid_Out  <= emit;
            bus.Frame_Done <= bus.Valid_In && col_last && row_last;
            if (emit) begin
                bus.Data_Out <= out_nxt;
            end
            if (bus.Valid_In) begin
                col <= col_last ? '0 : col + CW'(1);
                if (col == CW'(KERNEL - 2)) begin
                    cph <= '0;
                end else begin
                    cph <= (cph == PHW'(STRIDE - 1)) ? '0 : cph + PHW'(1);
                end
                if (col_last) begin
                    row <= row_last ? '0 : row + RW'(1);
                    if (row == RW'(KERNEL - 2)) begin
                        rph <= '0;
                    end else begin
                        rph <= (rph == PHW'(STRIDE - 1)) ? '0 : rph + PHW'(1);
                    end
                end
            end
        end
    end

    // Line buffers are addressed by column, so each write shifts one pixel up a row.
    always_ff @(posedge clk) begin
        if (!rst && bus.Valid_In) begin
            win       <= win_nxt;
            lb[0][col] <= bus.Data_In;
            for (int j = 1; j < KERNEL - 1; j++) begin
                lb[j][col] <= lb[j-1][col];
            end
        end
    end
endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer: 5x5 stride-1/stride-2 instances share one stream; a 44x44x4 instance runs last.
module tb_conv_window_buffer;
    localparam int W = 5, H = 5, K = 3;
    localparam int BW = 44, BH = 44, BC = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vin;
    logic [7:0]  din;
    logic        bvin;
    logic [31:0] bdin;

    conv_window_buffer_if #(.DATA_WIDHT(8), .CHANNEL_IN(1),  .KERNEL(3)) if1 ();
    conv_window_buffer_if #(.DATA_WIDHT(8), .CHANNEL_IN(1),  .KERNEL(3)) if2 ();
    conv_window_buffer_if #(.DATA_WIDHT(8), .CHANNEL_IN(BC), .KERNEL(3)) ifb ();

    assign if1.Data_In  = din;
    assign if1.Valid_In = vin;
    assign if2.Data_In  = din;
    assign if2.Valid_In = vin;
    assign ifb.Data_In  = bdin;
    assign ifb.Valid_In = bvin;

    conv_window_buffer #(.DATA_WIDHT(8), .CHANNEL_IN(1), .IMG_WIDHT(W), .IMG_HEIGHT(H),
                         .KERNEL(K), .STRIDE(1)) u_s1 (.clk(clk), .rst(rst), .bus(if1.slave));
    conv_window_buffer #(.DATA_WIDHT(8), .CHANNEL_IN(1), .IMG_WIDHT(W), .IMG_HEIGHT(H),
                         .KERNEL(K), .STRIDE(2)) u_s2 (.clk(clk), .rst(rst), .bus(if2.slave));
    conv_window_buffer #(.DATA_WIDHT(8), .CHANNEL_IN(BC), .IMG_WIDHT(BW), .IMG_HEIGHT(BH),
                         .KERNEL(K), .STRIDE(1)) u_big (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct {
        int         dut;
        int         idx;
        int         beat;
        logic [7:0] tl;
    } exp_win_t;
    exp_win_t tbl [13];

    int nchk = 0;
    int nerr = 0;

    // small-frame reference model
    int          pos;
    int          pix [H][W];
    logic        exp_vld [2];
    logic [71:0] exp_dat [2];
    logic        exp_fd;

    // pulse recording
    logic [71:0] rec_dat  [2][32];
    int          rec_beat [2][32];
    int          pcnt [2];
    int          fdcnt;
    int          fd_at_pulse;

    // large-frame reference model
    int           bpos;
    int           bpix [BH][BW];
    logic [287:0] bexp;
    logic         bexp_vld;
    logic         bexp_fd;
    int           bwin;
    int           bfd;

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        pcnt[0] = 0; pcnt[1] = 0; fdcnt = 0; fd_at_pulse = -1;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++) begin
                rec_dat[s][i]  = '0;
                rec_beat[s][i] = -1;
            end
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] d);
        int row, col, bp;
        rst = r; vin = v; din = d;
        @(posedge clk);
        #1;
        bp = -1;
        if (r) begin
            pos = 0;
            for (int s = 0; s < 2; s++) begin exp_vld[s] = 1'b0; exp_dat[s] = '0; end
            exp_fd = 1'b0;
            bpos = 0; bexp = '0;
        end else if (v) begin
            row = pos / W;
            col = pos % W;
            pix[row][col] = d;
            for (int s = 0; s < 2; s++) begin
                exp_vld[s] = (row >= K-1) && (col >= K-1) &&
                             ((row-K+1) % (s+1) == 0) && ((col-K+1) % (s+1) == 0);
                if (exp_vld[s])
                    for (int rr = 0; rr < K; rr++)
                        for (int kk = 0; kk < K; kk++)
                            exp_dat[s][(rr*K+kk)*8 +: 8] = 8'(pix[row-K+1+rr][col-K+1+kk]);
            end
            exp_fd = (pos == W*H-1);
            bp  = pos;
            pos = (pos + 1) % (W*H);
        end else begin
            exp_vld[0] = 1'b0; exp_vld[1] = 1'b0; exp_fd = 1'b0;
        end
        chk("vld_s1", if1.Valid_Out, exp_vld[0]);
        chk("dat_s1", if1.Data_Out, exp_dat[0]);
        chk("fd_s1", if1.Frame_Done, exp_fd);
        chk("vld_s2", if2.Valid_Out, exp_vld[1]);
        chk("dat_s2", if2.Data_Out, exp_dat[1]);
        chk("fd_s2", if2.Frame_Done, exp_fd);
        if (!r) begin
            if (if1.Valid_Out === 1'b1) begin
                if (pcnt[0] < 32) begin rec_dat[0][pcnt[0]] = if1.Data_Out; rec_beat[0][pcnt[0]] = bp; end
                pcnt[0]++;
            end
            if (if2.Valid_Out === 1'b1) begin
                if (pcnt[1] < 32) begin rec_dat[1][pcnt[1]] = if2.Data_Out; rec_beat[1][pcnt[1]] = bp; end
                pcnt[1]++;
            end
            if (if1.Frame_Done === 1'b1) begin fdcnt++; fd_at_pulse = pcnt[0]; end
        end
        rst = 1'b0;
    endtask

    task automatic frame(input int off, input int maxgap, input bit rnd);
        for (int i = 0; i < W*H; i++) begin
            int gap;
            gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 8'($urandom));
            if (rnd) cyc(1'b0, 1'b1, 8'($urandom));
            else     cyc(1'b0, 1'b1, 8'((i / W) * 16 + (i % W) + off));
        end
    endtask

    task automatic check_tbl(input bit with_s2, input int base);
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].dut == 0 || with_s2) begin
                chk("tbl_beat", rec_beat[tbl[i].dut][base + tbl[i].idx], tbl[i].beat);
                chk("tbl_tl", rec_dat[tbl[i].dut][base + tbl[i].idx][7:0], tbl[i].tl);
                chk("tbl_br", rec_dat[tbl[i].dut][base + tbl[i].idx][71:64], 8'(tbl[i].tl + 8'h22));
            end
        end
    endtask

    task automatic bcyc(input bit v, input int p);
        int row, col;
        logic ok;
        logic [287:0] o;
        rst = 1'b0; bvin = v;
        for (int c = 0; c < BC; c++) bdin[c*8 +: 8] = 8'(p + c);
        @(posedge clk);
        #1;
        bexp_vld = 1'b0; bexp_fd = 1'b0;
        if (v) begin
            row = bpos / BW;
            col = bpos % BW;
            bpix[row][col] = p;
            bexp_vld = (row >= K-1) && (col >= K-1);
            if (bexp_vld)
                for (int rr = 0; rr < K; rr++)
                    for (int kk = 0; kk < K; kk++)
                        for (int c = 0; c < BC; c++)
                            bexp[((rr*K+kk)*BC+c)*8 +: 8] = 8'(bpix[row-K+1+rr][col-K+1+kk] + c);
            bexp_fd = (bpos == BW*BH-1);
            bpos = (bpos + 1) % (BW*BH);
        end
        chk("big_vld", ifb.Valid_Out, bexp_vld);
        chk("big_fd", ifb.Frame_Done, bexp_fd);
        chk("big_dat", ifb.Data_Out, bexp);
        if (ifb.Valid_Out === 1'b1) begin
            bwin++;
            o  = ifb.Data_Out;
            ok = 1'b1;
            for (int e = 0; e < K*K; e++)
                for (int c = 1; c < BC; c++)
                    if (o[(e*BC+c)*8 +: 8] !== 8'(o[(e*BC)*8 +: 8] + c)) ok = 1'b0;
            chk("big_chan", ok, 1'b1);
        end
        if (ifb.Frame_Done === 1'b1) bfd++;
    endtask

    initial begin
        tbl = '{
            '{0, 0, 12, 8'h00}, '{0, 1, 13, 8'h01}, '{0, 2, 14, 8'h02},
            '{0, 3, 17, 8'h10}, '{0, 4, 18, 8'h11}, '{0, 5, 19, 8'h12},
            '{0, 6, 22, 8'h20}, '{0, 7, 23, 8'h21}, '{0, 8, 24, 8'h22},
            '{1, 0, 12, 8'h00}, '{1, 1, 14, 8'h02}, '{1, 2, 22, 8'h20}, '{1, 3, 24, 8'h22}
        };
        rst = 1'b1; vin = 1'b0; din = '0; bvin = 1'b0; bdin = '0;
        pos = 0; bpos = 0; bexp = '0; bwin = 0; bfd = 0;
        exp_fd = 1'b0;
        for (int s = 0; s < 2; s++) begin exp_vld[s] = 1'b0; exp_dat[s] = '0; end
        clear_rec();

        // reset state
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h55);
        chk("rst_big_vld", ifb.Valid_Out, 1'b0);
        chk("rst_big_dat", ifb.Data_Out, 288'h0);

        // continuous frame, both strides
        clear_rec();
        frame(0, 0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("s1_pulses", pcnt[0], 9);
        chk("s2_pulses", pcnt[1], 4);
        chk("s1_fd_cnt", fdcnt, 1);
        chk("fd_with_9th", fd_at_pulse, 9);
        chk("first_win", rec_dat[0][0], 72'h22_21_20_12_11_10_02_01_00);
        check_tbl(1'b1, 0);

        // random gaps
        clear_rec();
        frame(0, 3, 1'b0);
        chk("gap_pulses", pcnt[0], 9);
        chk("gap_fd_cnt", fdcnt, 1);
        check_tbl(1'b1, 0);

        // back-to-back frames
        clear_rec();
        frame(0, 0, 1'b0);
        frame(8'h80, 0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("b2b_pulses", pcnt[0], 18);
        chk("b2b_fd_cnt", fdcnt, 2);
        chk("b2b_first2", rec_dat[0][9], 72'ha2_a1_a0_92_91_90_82_81_80);
        check_tbl(1'b0, 0);

        // reset mid-frame, with a beat colliding with reset
        clear_rec();
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'((i / W) * 16 + (i % W)));
        cyc(1'b1, 1'b1, 8'hee);
        chk("abort_fd", fdcnt, 0);
        clear_rec();
        frame(0, 0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("post_rst_pulses", pcnt[0], 9);
        chk("post_rst_fd", fdcnt, 1);
        check_tbl(1'b1, 0);

        // random pixel data with random gaps
        clear_rec();
        frame(0, 2, 1'b1);
        frame(0, 1, 1'b1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("rnd_pulses_s1", pcnt[0], 18);
        chk("rnd_pulses_s2", pcnt[1], 8);

        // 44x44, 4 channels
        for (int i = 0; i < BW*BH; i++) begin
            if (i % 97 == 50) bcyc(1'b0, 0);
            bcyc(1'b1, (i / BW) * 16 + (i % BW));
        end
        bcyc(1'b0, 0);
        chk("big_windows", bwin, 1764);
        chk("big_fd_cnt", bfd, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/conv_window_buffer.md
# conv_window_buffer

Parametrised sliding-window generator for the convolution layers. Accepts one multi-channel pixel per valid beat in raster order and emits a registered KERNEL×KERNEL×CHANNEL_IN window for each output position. It supports configurable stride and back-to-back frames, and pulses a frame-done flag. It sits between a layer's input stream and its MAC array, replacing the fixed 3×3, stride-1 window logic in the per-layer modules.

## Interface
- DATA_WIDHT, 32, bits per channel sample
- CHANNEL_IN, 8, channels per pixel beat
- IMG_WIDHT, 44, pixels per row (≥ KERNEL)
- IMG_HEIGHT, 44, rows per frame (≥ KERNEL)
- KERNEL, 3, window side (≥ 2)
- STRIDE, 1, window step in both directions (≥ 1)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- Data_In  in  DATA_WIDHT*CHANNEL_IN  pixel; channel c at [c*DATA_WIDHT +: DATA_WIDHT]
- Valid_In  in  1  Data_In is a pixel beat this cycle
- Data_Out  out  DATA_WIDHT*CHANNEL_IN*KERNEL*KERNEL  window. Element e = r*KERNEL+k, where r = 0 is the top (oldest) row and k = 0 is the left column. Channel c is at [(e*CHANNEL_IN+c)*DATA_WIDHT +: DATA_WIDHT].
- Valid_Out  out  1  Data_Out holds a new window (one-cycle pulse per window)
- Frame_Done  out  1  one-cycle pulse after the last window of a frame

## Operation
- Column counter col (0..IMG_WIDHT-1) and row counter row (0..IMG_HEIGHT-1) advance only on Valid_In beats.
  - col wraps to 0 and increments row.
  - After (IMG_HEIGHT-1, IMG_WIDHT-1), both wrap to 0. The next beat is pixel (0,0) of a new frame, with no idle cycle required.
- KERNEL-1 line buffers, each IMG_WIDHT deep, are chained as a shift structure on each beat, so a beat at (row,col) presents column col of rows row-KERNEL+1..row.
- KERNEL×KERNEL window register shifts left by one column on each beat. The incoming column is loaded at k = KERNEL-1.
- A beat at (row,col) completes window W with bottom-right (row,col). W is emitted when all of the following hold:
  - row ≥ KERNEL-1 and col ≥ KERNEL-1
  - (row-KERNEL+1) mod STRIDE = 0
  - (col-KERNEL+1) mod STRIDE = 0
- The modulo conditions are implemented with row/column phase counters, not dividers. Phase counters reset at row = KERNEL-1 and col = KERNEL-1 respectively.
- Windows per frame = (floor((IMG_HEIGHT-KERNEL)/STRIDE)+1) × (floor((IMG_WIDHT-KERNEL)/STRIDE)+1). Trailing rows and columns that cannot start a full stride step are ignored.
- Line-buffer contents from the previous frame are stale at frame start. They are never emitted because of the row ≥ KERNEL-1 gate.
- No backpressure: the consumer must accept every Valid_Out pulse.
- Data is passed unmodified. No arithmetic is performed on samples.

## Timing
- Reset (rst = 1 at a rising edge):
  - Valid_Out = 0, Frame_Done = 0, Data_Out = 0.
  - Counters and phase counters are set to 0.
  - Line-buffer contents are don't-care.
- Latency: Valid_Out and Data_Out update on the edge that samples the completing Valid_In beat, i.e. they are visible 1 cycle after the beat.
- Data_Out holds its value until the next emitted window.
- Valid_In low: no state moves, and Valid_Out / Frame_Done are 0 in the following cycle. Gaps of any length are legal anywhere, including mid-row and across the frame boundary.
- Frame_Done asserts 1 cycle after the beat at (IMG_HEIGHT-1, IMG_WIDHT-1). This is the same cycle as Valid_Out if that beat emits a window.
- rst during a frame: the partial frame is discarded, no Frame_Done is issued, and the next beat is treated as pixel (0,0).
- rst and Valid_In high in the same cycle: rst wins and the beat is dropped.
- Throughput: one pixel per cycle sustained. At most one window per cycle.

## Test plan
All scenarios use DATA_WIDHT=8, CHANNEL_IN=1, IMG_WIDHT=IMG_HEIGHT=5, KERNEL=3, and pixel value = row*16+col, unless stated otherwise.

1. STRIDE=1, continuous Valid_In for 25 beats:
   - exactly 9 Valid_Out pulses
   - first pulse 1 cycle after beat 12, with elements 00,01,02,10,11,12,20,21,22
   - last window top-left element = 0x22
   - Frame_Done coincides with the 9th pulse
2. STRIDE=2, continuous Valid_In:
   - 4 windows, with top-left elements 0x00, 0x02, 0x20, 0x22
   - no Valid_Out at beats with odd col-2 or odd row-2
3. STRIDE=1 with random 0–3-cycle gaps in Valid_In: window sequence and contents are identical to scenario 1, with Valid_Out never asserted during a gap.
4. Two frames back-to-back (second frame values + 0x80): 18 pulses and 2 Frame_Done pulses. The first window of the second frame contains only 0x80-offset values.
5. rst asserted for one cycle after beat 15, then a fresh 25-beat frame: no Frame_Done for the aborted frame, and exactly 9 correct windows after reset.
6. CHANNEL_IN=4, channel c value = pixel+c, IMG_WIDHT=IMG_HEIGHT=44, STRIDE=1: 1764 windows, and every window element's channel c equals channel 0 + c.
